// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the multiplexed address/data bus: one-hot cycle states and bus widths.
package bus_initiator_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int WAIT_W = 8;

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    TW   = 6'b001000,
    T3   = 6'b010000,
    T4   = 6'b100000
  } bus_state_e;

endpackage

// File: rtl/bus_initiator.sv
// Bus initiator for a multiplexed low-address/data bus with ALE, active-low strobes,
// ready-driven wait states and a wait-state timeout that aborts the cycle.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ready,
  input  logic [DATA_W-1:0] ad_in,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic              CS,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic [DATA_W-1:0] a_hi,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [WAIT_W-1:0] TW_LAST = WAIT_W'(TIMEOUT - 1);

  bus_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              strobe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
          state_d = T1;
        end
      end
      T1: state_d = T2;
      T2: state_d = ready ? T3 : TW;
      TW: begin
        // ready takes priority over the timeout when both land in the same cycle
        if (ready) begin
          state_d = T3;
        end else if (cnt_q == TW_LAST) begin
          state_d = T4;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      T3: begin
        if (!we_q) rdata_d = ad_in;
        state_d = T4;
      end
      T4:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    strobe = (state_q == T2) || (state_q == TW) || (state_q == T3);
    ALE    = (state_q == T1);
    CS     = !((state_q == T1) || strobe);
    RD     = !(strobe && !we_q);
    WR     = !(strobe && we_q);
    ad_oe  = (state_q == T1) || (strobe && we_q);
    ad_out = '0;
    if (state_q == T1) begin
      ad_out = addr_q[DATA_W-1:0];
    end else if (strobe && we_q) begin
      ad_out = wdata_q;
    end
    a_hi   = addr_q[ADDR_W-1:DATA_W];
    rdata  = rdata_q;
    busy   = (state_q != IDLE);
    done   = (state_q == T4);
    err    = err_q;
  end

endmodule
